// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e       : controller states (idle, running, result presented)
//   DefaultWidth  : default operand/result width in bits
//   DefaultDigit  : default number of bits processed per cycle
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDigit = 1;

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple-carry adder for one digit of the serial datapath.
// Ports:
//   x, y : digit operands (WIDTH bits)
//   cin  : carry in from the previous digit
//   s    : digit sum (WIDTH bits)
//   co   : carry out of the digit's top bit
module digit_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Processes DIGIT bits per cycle, LSB digit first,
// completing one WIDTH-bit operation in WIDTH/DIGIT cycles.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   start : begin an operation (ignored while busy)
//   sub   : 0 = a+b, 1 = a-b (captured with start)
//   a, b  : operands (captured with start)
//   busy  : operation in progress
//   done  : one-cycle pulse, result valid
//   sum   : registered result, held until next done
//   cout  : carry out (in subtract mode 1 = no borrow)
//   ovf   : signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIGIT = DefaultDigit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned Steps = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 2");
  end
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must be nonzero and divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;      // already inverted in subtract mode
  logic [WIDTH-1:0]  acc_q, acc_d;  // partial result, filled from the top
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [DIGIT-1:0]  dig_x, dig_y, dig_s;
  logic              dig_co;
  logic [WIDTH-1:0]  acc_next;
  logic              capture;
  logic              last_step;

  assign dig_x = a_q[DIGIT-1:0];
  assign dig_y = b_q[DIGIT-1:0];

  digit_adder #(
    .WIDTH(DIGIT)
  ) u_digit_adder (
    .x  (dig_x),
    .y  (dig_y),
    .cin(carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // New digit enters at the top; after Steps shifts the LSB digit sits at bit 0.
  assign acc_next  = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign last_step = (cnt_q == CntW'(Steps - 1));
  assign capture   = start && (state_q != StRun);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  // Carry into the MSB recovered from the top bit of the final digit.
  logic msb_cin;
  assign msb_cin = dig_x[DIGIT-1] ^ dig_y[DIGIT-1] ^ dig_s[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    if (capture) begin
      state_d = StRun;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = dig_co;
          acc_d   = acc_next;
          cnt_d   = cnt_q + CntW'(1);
          if (last_step) begin
            state_d = StDone;
            sum_d   = acc_next;
            cout_d  = dig_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d   = msb_cin ^ dig_co;
`endif
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
